mux4to1_rr: RTL and testbench
=============================

Name: mux4to1_rr

Overview:
- Merges four input channels into one output stream, using a one-entry registered output stage and round-robin arbitration.
- Counterpart of the 1-to-4 enabled demux: each output word carries its source index `out_s`, so a downstream demux driven with `s = out_s` routes the word back to its original channel index.
- Sits between four producer channels and a single shared consumer or link.

Parameters:
- DW, 8, data width of each channel and of the output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- En  input  1  grant enable. 0 = no new words accepted; a word already held may still drain.
- in_valid  input  4  per-channel valid. Bit i is channel i.
- in_data  input  4*DW  channel i data is in_data[i*DW +: DW].
- in_ready  output  4  one-hot (or zero) grant. Combinational.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DW  held word.
- out_s  output  2  source channel index of the held word.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_s=0, rr pointer ptr=0.
  - in_ready=0 while rst=1.
  - Reset in the middle of a hold discards the held word. No input transfer occurs in a reset cycle.
- State, implicit in out_valid:
  - EMPTY (out_valid=0) or FULL (out_valid=1).
  - `slot_free = !out_valid | out_ready`.
- Arbitration, combinational:
  - Applies when En=1, rst=0 and slot_free=1.
  - Search order: channels ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first channel with in_valid set is granted: in_ready[g]=1, all other bits 0.
  - If no channel is valid, in_ready=0.
  - En=0 or slot_free=0 → in_ready=4'b0000.
- Input transfer: occurs on in_valid[g] & in_ready[g] at a clk edge.
  - Next cycle: out_valid=1, out_data=in_data[g], out_s=g.
  - ptr ← g+1 mod 4, wrapping 3→0.
- Output transfer: occurs on out_valid & out_ready.
  - If a new input transfer happens in the same cycle, the register reloads: out_valid stays 1, giving back-to-back throughput of 1 word/cycle.
  - Otherwise out_valid ← 0.
- Stall: while out_valid=1 and out_ready=0, out_data and out_s hold stable and in_ready=0.
- Latency: 1 cycle from input accept to out_valid.
- Transitions:
  - EMPTY→FULL on an input transfer.
  - FULL→EMPTY on an output transfer with no input transfer.
  - FULL→FULL on reload, or on stall.
- ptr is unchanged when no grant occurs.
  - With En=0, ptr is frozen.
  - ptr is also unchanged if in_valid drops before a grant.
- Producers must hold in_valid and in_data until accepted. The block does not check this.
- En falls while FULL → the held word still drains normally, and no reload happens.
- Fairness: a channel that stays continuously valid is granted at least once every 4 grants.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_s=0, in_ready=0 during reset. After release with En=1 and out_ready=1, the first grant goes to channel 0.
- Enable gating: En=0, in_valid=4'b1111, data ch0..3 = 8'h10,8'h11,8'h12,8'h13 for 5 cycles → in_ready=0 and out_valid=0 throughout. Raise En → ch0 (8'h10, out_s=0) appears 1 cycle later.
- Round-robin wrap: En=1, all valid, out_ready=1 for 8 cycles → out_s sequence 0,1,2,3,0,1,2,3. out_data sequence 10,11,12,13,10,11,12,13. out_valid=1 every cycle after the first.
- Sparse fairness: in_valid=4'b1010 continuously, out_ready=1 → out_s alternates 1,3,1,3. Channels 0 and 2 never see in_ready.
- Backpressure: hold word 8'h12 (out_s=2) with out_ready=0 for 4 cycles → out_data and out_s stable, in_ready=0. Then out_ready=1 → same-cycle reload of the next channel (3), and out_valid never drops.
- Reset mid-hold: out_valid=1 with out_ready=0, pulse rst → next cycle out_valid=0 and ptr=0. The held word is never delivered.

Source files
------------

// File: rtl/mux4to1_rr.sv
// Four-channel round-robin merge into a single registered output slot.
// Each held word carries its source channel index on out_s so a downstream demux can route it back.
module mux4to1_rr #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            En,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_s
);

    // Returns {found, index} of the first valid channel searching from ptr upward, mod 4.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] vld);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (vld[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [1:0]      out_s_q, out_s_d;
    logic [1:0]      ptr_q, ptr_d;

    logic            slot_free;
    logic            arb_en;
    logic [2:0]      pick;
    logic            grant_vld;
    logic [1:0]      grant_idx;
    logic            xfer_in;
    logic            xfer_out;

    always_comb begin
        slot_free = !out_valid_q || out_ready;
        arb_en    = En && !rst && slot_free;
        pick      = rr_pick(ptr_q, in_valid);
        grant_vld = arb_en && pick[2];
        grant_idx = pick[1:0];
        in_ready  = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
        xfer_in   = |(in_valid & in_ready);
        xfer_out  = out_valid_q && out_ready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_s_d     = out_s_q;
        ptr_d       = ptr_q;
        if (xfer_in) begin
            // Covers both an empty-slot load and a same-cycle reload behind a drain.
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant_idx*DW +: DW];
            out_s_d     = grant_idx;
            ptr_d       = grant_idx + 2'd1;
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_s_q     <= 2'd0;
            ptr_q       <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_s_q     <= out_s_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_s     = out_s_q;

endmodule

// File: tb/tb_mux4to1_rr.sv
// Randomized and directed bench for mux4to1_rr with a queue scoreboard
// fed by a channel-order reference model and drained by an output monitor.
module tb_mux4to1_rr;

    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    s;
    } item_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            En = 1'b0;
    logic [3:0]      in_valid = 4'b0;
    logic [4*DW-1:0] in_data = '0;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_s;

    logic [DW-1:0]   ch_data [4];
    item_t           exp_q [$];
    int              sent_log [$];
    int              exp_log [$];
    int              m_ptr = 0;
    int              checks = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    mux4to1_rr #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .En(En),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_s(out_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, 32'(sent_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < sent_log.size() && i < exp_log.size(); i++)
            check({name, "_s"}, 32'(sent_log[i]), 32'(exp_log[i]));
        sent_log.delete();
    endtask

    // Monitor: output state at negedge+1 against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
                if (out_valid && exp_q.size() != 0) begin
                    check("out_data", 32'(out_data), 32'(exp_q[0].d));
                    check("out_s", 32'(out_s), 32'(exp_q[0].s));
                    if (out_ready) begin
                        sent_log.push_back(int'(out_s));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // One clock of stimulus, then the reference model decides the grant at negedge+2.
    task automatic cycle(input logic r, input logic e, input logic [3:0] v, input logic o);
        logic [3:0] exp_rdy;
        int         c;
        @(negedge clk);
        rst       = r;
        En        = e;
        in_valid  = v;
        out_ready = o;
        for (int i = 0; i < 4; i++) in_data[i*DW +: DW] = ch_data[i];
        #2;
        exp_rdy = 4'b0000;
        if (r) begin
            exp_q.delete();
            m_ptr = 0;
        end else if (e && exp_q.size() == 0) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (v[c] && exp_rdy == 4'b0000) exp_rdy[c] = 1'b1;
            end
        end
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                exp_q.push_back('{d: ch_data[i], s: 2'(i)});
                m_ptr = (i + 1) % 4;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ch_data[i] = 8'h10 + 8'(i);

        cycle(1'b1, 1'b1, 4'b1111, 1'b1);
        cycle(1'b1, 1'b1, 4'b1111, 1'b1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_s", 32'(out_s), 32'd0);

        repeat (5) cycle(1'b0, 1'b0, 4'b1111, 1'b1);
        cycle(1'b0, 1'b1, 4'b1111, 1'b1);
        check("first_grant", 32'(in_ready), 32'd1);
        repeat (2) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
        exp_log = '{0};
        check_log("en_gate");

        cycle(1'b1, 1'b0, 4'b0000, 1'b1);
        repeat (8) cycle(1'b0, 1'b1, 4'b1111, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
        exp_log = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log("rr_wrap");

        cycle(1'b1, 1'b0, 4'b0000, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 4'b1010, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
        exp_log = '{1, 3, 1, 3};
        check_log("sparse");

        cycle(1'b1, 1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 1'b1, 4'b0100, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 4'b1111, 1'b0);
        cycle(1'b0, 1'b1, 4'b1111, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
        exp_log = '{2, 3};
        check_log("backpressure");

        cycle(1'b0, 1'b1, 4'b0001, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 4'b0000, 1'b0);
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 1'b1, 4'b1111, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
        exp_log = '{0};
        check_log("rst_mid_hold");

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) ch_data[i] = 8'($urandom);
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
                  4'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (3) cycle(1'b0, 1'b0, 4'b0000, 1'b1);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
